// File: rtl/vga_timing_pkg.sv
// Shared raster constants for the VGA timing generator (640x480 @ 60 Hz from 50 MHz)
// and the helper that turns an axis' region widths into its total length.
package vga_timing_pkg;

  localparam int DEF_COUNTER_BITS = 10;
  localparam int DEF_CLK_DIV      = 2;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;

  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  function automatic int axis_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  localparam int DEF_H_TOTAL      = axis_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int DEF_V_TOTAL      = axis_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);
  localparam int DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered visible and sync flags
// that always describe the current count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int BITS    = DEF_COUNTER_BITS,
  parameter int VISIBLE = DEF_H_VISIBLE,
  parameter int FRONT   = DEF_H_FRONT,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BACK    = DEF_H_BACK
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance,
  output logic [BITS-1:0] count,
  output logic            active,
  output logic            sync_n,
  output logic            terminal
);

  localparam int TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);
  localparam logic [BITS-1:0] LAST_L       = BITS'(TOTAL - 1);
  localparam logic [BITS-1:0] VISIBLE_L    = BITS'(VISIBLE);
  localparam logic [BITS-1:0] SYNC_START_L = BITS'(VISIBLE + FRONT);
  localparam logic [BITS-1:0] SYNC_END_L   = BITS'(VISIBLE + FRONT + SYNC);

  logic [BITS-1:0] count_r;
  logic [BITS-1:0] count_nxt_s;
  logic            active_r;
  logic            sync_n_r;
  logic            terminal_s;

  assign terminal_s = (count_r == LAST_L);

  // Next position: wrap after the last count, otherwise step by one.
  always_comb begin
    count_nxt_s = {BITS{1'b0}};
    if (terminal_s) begin
      count_nxt_s = {BITS{1'b0}};
    end else begin
      count_nxt_s = count_r + {{(BITS-1){1'b0}}, 1'b1};
    end
  end

  // Flags are computed from the next count so they change on the same edge as the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r  <= LAST_L;
      active_r <= 1'b0;
      sync_n_r <= 1'b1;
    end else if (advance) begin
      count_r  <= count_nxt_s;
      active_r <= (count_nxt_s < VISIBLE_L);
      sync_n_r <= !((count_nxt_s >= SYNC_START_L) && (count_nxt_s < SYNC_END_L));
    end
  end

  assign count    = count_r;
  assign active   = active_r;
  assign sync_n   = sync_n_r;
  assign terminal = terminal_s;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider feeding cascaded horizontal and
// vertical axis counters, with registered bright, sync, pixel-enable and frame-start.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int COUNTER_BITS = DEF_COUNTER_BITS,
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int H_VISIBLE    = DEF_H_VISIBLE,
  parameter int H_FRONT      = DEF_H_FRONT,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BACK       = DEF_H_BACK,
  parameter int V_VISIBLE    = DEF_V_VISIBLE,
  parameter int V_FRONT      = DEF_V_FRONT,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BACK       = DEF_V_BACK
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic [COUNTER_BITS-1:0] h_count,
  output logic [COUNTER_BITS-1:0] v_count,
  output logic                    bright,
  output logic                    hsync_n,
  output logic                    vsync_n,
  output logic                    pix_en,
  output logic                    frame_start
);

  localparam int DIV_BITS = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_BITS-1:0]     DIV_LAST_L  = DIV_BITS'(CLK_DIV - 1);
  localparam logic [COUNTER_BITS-1:0] H_VIS_M1_L  = COUNTER_BITS'(H_VISIBLE - 1);
  localparam logic [COUNTER_BITS-1:0] V_VIS_M1_L  = COUNTER_BITS'(V_VISIBLE - 1);

  logic [DIV_BITS-1:0]     div_r;
  logic                    advance_s;
  logic                    v_en_s;
  logic [COUNTER_BITS-1:0] h_count_s;
  logic [COUNTER_BITS-1:0] v_count_s;
  logic                    h_active_s, v_active_s;
  logic                    h_term_s, v_term_s;
  logic                    h_next_active_s, v_next_active_s;
  logic                    bright_r, pix_en_r, frame_start_r;

  assign advance_s = (div_r == DIV_LAST_L);
  assign v_en_s    = advance_s & h_term_s;

  vga_axis_counter #(
    .BITS(COUNTER_BITS), .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h_axis (
    .clk(clk), .rst_n(rst_n), .advance(advance_s),
    .count(h_count_s), .active(h_active_s), .sync_n(hsync_n), .terminal(h_term_s)
  );

  vga_axis_counter #(
    .BITS(COUNTER_BITS), .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v_axis (
    .clk(clk), .rst_n(rst_n), .advance(v_en_s),
    .count(v_count_s), .active(v_active_s), .sync_n(vsync_n), .terminal(v_term_s)
  );

  // Visibility of the position after this edge: a wrap lands on 0 (visible); otherwise
  // visibility persists until the last visible count is left.
  always_comb begin
    h_next_active_s = h_term_s || (h_active_s && (h_count_s != H_VIS_M1_L));
    v_next_active_s = v_active_s;
    if (v_en_s) begin
      v_next_active_s = v_term_s || (v_active_s && (v_count_s != V_VIS_M1_L));
    end else begin
      v_next_active_s = v_active_s;
    end
  end

  // Pixel divider and the registered per-pixel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r         <= {DIV_BITS{1'b0}};
      bright_r      <= 1'b0;
      pix_en_r      <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      div_r         <= advance_s ? {DIV_BITS{1'b0}} : div_r + {{(DIV_BITS-1){1'b0}}, 1'b1};
      pix_en_r      <= advance_s;
      frame_start_r <= advance_s & h_term_s & v_term_s;
      if (advance_s) begin
        bright_r <= h_next_active_s & v_next_active_s;
      end
    end
  end

  assign h_count     = h_count_s;
  assign v_count     = v_count_s;
  assign bright      = bright_r;
  assign pix_en      = pix_en_r;
  assign frame_start = frame_start_r;

endmodule
